// File: rtl/scratch_pkg.sv
// Shared types, default sizes and request-priority decode for the scratch RAM stack.
package scratch_pkg;

  localparam int unsigned DefDataW = 10;
  localparam int unsigned DefAddrW = 8;

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  // Requests that survive priority resolution (stack-limit checks come later).
  typedef struct packed {
    logic clr;
    logic ld;
    logic push;
    logic pop;
    logic we;
  } req_t;

  // CLR > SP_LD > PUSH/POP > WE; PUSH+POP cancel; POP may pair with WE.
  function automatic req_t decode_req(input logic busy, input logic clr, input logic sp_ld,
                                      input logic push, input logic pop, input logic we);
    req_t r;
    r     = '0;
    r.clr = clr;
    if (!clr && !busy) begin
      if (sp_ld) begin
        r.ld = 1'b1;
      end else if (push && pop) begin
        r = '0;
      end else if (push) begin
        r.push = 1'b1;
      end else begin
        r.pop = pop;
        r.we  = we;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/scratch_sp_unit.sv
// Stack pointer, stack depth counter and sticky overflow/underflow flags.
module scratch_sp_unit
  import scratch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = DefAddrW,
  parameter logic [ADDR_W-1:0] SP_RESET = '0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              busy_i,
  input  logic              clr_i,
  input  logic              sp_ld_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] sp_in_i,
  output logic              push_o,
  output logic              we_o,
  output logic [ADDR_W-1:0] sp_o,
  output logic [ADDR_W-1:0] sp_next_o,
  output logic              ovf_o,
  output logic              udf_o
);

  localparam logic [ADDR_W:0] Full = {1'b1, {ADDR_W{1'b0}}};

  logic [ADDR_W-1:0] sp_q, sp_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  req_t              req;

  // Resolve simultaneous requests before applying stack limits.
  always_comb req = decode_req(busy_i, clr_i, sp_ld_i, push_i, pop_i, we_i);

  // Next-state for SP/count/flags; push is qualified by the full check.
  always_comb begin
    sp_d   = sp_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    udf_d  = udf_q;
    push_o = 1'b0;
    if (req.clr) begin
      sp_d  = SP_RESET;
      cnt_d = '0;
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end else if (req.ld) begin
      sp_d  = sp_in_i;
      cnt_d = '0;
    end else if (req.push) begin
      if (cnt_q == Full) begin
        ovf_d = 1'b1;
      end else begin
        push_o = 1'b1;
        sp_d   = sp_q - 1'b1;
        cnt_d  = cnt_q + 1'b1;
      end
    end else if (req.pop) begin
      if (cnt_q == '0) begin
        udf_d = 1'b1;
      end else begin
        sp_d  = sp_q + 1'b1;
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  // Stack state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sp_q  <= SP_RESET;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign we_o      = req.we;
  assign sp_o      = sp_q;
  assign sp_next_o = sp_d;  // equals SP-1 whenever push_o is set
  assign ovf_o     = ovf_q;
  assign udf_o     = udf_q;

endmodule

// File: rtl/scratch_ram_stack.sv
// Scratch RAM with hardware stack and self-clearing sweep after reset or CLR.
module scratch_ram_stack
  import scratch_pkg::*;
#(
  parameter int unsigned       DATA_W   = DefDataW,
  parameter int unsigned       ADDR_W   = DefAddrW,
  parameter logic [ADDR_W-1:0] SP_RESET = '0
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              CLR,
  input  logic              WE,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [DATA_W-1:0] DATA_IN,
  input  logic              PUSH,
  input  logic              POP,
  input  logic              SP_LD,
  input  logic [ADDR_W-1:0] SP_IN,
  output logic [DATA_W-1:0] DATA_OUT,
  output logic [ADDR_W-1:0] SP_OUT,
  output logic              BUSY,
  output logic              OVF,
  output logic              UDF
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] ram_q [DEPTH];
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic              busy;
  logic              push_ok, we_ok;
  logic [ADDR_W-1:0] sp, sp_next;

  assign busy = (state_q == StClear);

  scratch_sp_unit #(
    .ADDR_W  (ADDR_W),
    .SP_RESET(SP_RESET)
  ) u_sp (
    .clk_i    (CLK),
    .rst_ni   (RST_N),
    .busy_i   (busy),
    .clr_i    (CLR),
    .sp_ld_i  (SP_LD),
    .push_i   (PUSH),
    .pop_i    (POP),
    .we_i     (WE),
    .sp_in_i  (SP_IN),
    .push_o   (push_ok),
    .we_o     (we_ok),
    .sp_o     (sp),
    .sp_next_o(sp_next),
    .ovf_o    (OVF),
    .udf_o    (UDF)
  );

  // Clear sweep: CLR (re)starts at address 0; last address returns to idle.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    if (CLR) begin
      state_d   = StClear;
      clr_ptr_d = '0;
    end else if (state_q == StClear) begin
      clr_ptr_d = clr_ptr_q + 1'b1;
      if (&clr_ptr_q) begin
        state_d = StIdle;
      end
    end
  end

  // FSM register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= StClear;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  // Array write port: sweep, then push, then direct write.
  always_ff @(posedge CLK) begin
    if (busy) begin
      ram_q[clr_ptr_q] <= '0;
    end else if (push_ok) begin
      ram_q[sp_next] <= DATA_IN;
    end else if (we_ok) begin
      ram_q[ADDR] <= DATA_IN;
    end
  end

  // Combinational read: top of stack during POP, else direct address.
  always_comb begin
    DATA_OUT = '0;
    if (!busy) begin
      DATA_OUT = ram_q[POP ? sp : ADDR];
    end
  end

  assign SP_OUT = sp;
  assign BUSY   = busy;

endmodule
